// File: rtl/pu_int_ctrl_pkg.sv
// Shared types for the external interrupt controller: the Int_ctrl_reg layout
// and the exception-request bundle fed into Except_base.
package Pu_interrupt;

  localparam int GIN_WIDTH = 4;
  localparam int CTRL_WIDTH = 32;
  localparam int RSVD_WIDTH = CTRL_WIDTH - 1 - 3 * GIN_WIDTH;

  // Int_ctrl_reg: bits [3:0] mask, [7:4] trigger, [11:8] sense level, [12] doorbell enable.
  typedef struct packed {
    logic [RSVD_WIDTH-1:0] rsvd;
    logic                  doorbell_en;
    logic [GIN_WIDTH-1:0]  gin_sense_level;
    logic [GIN_WIDTH-1:0]  gin_trigger;
    logic [GIN_WIDTH-1:0]  gin_mask;
  } Int_ctrl_reg;

  typedef struct packed {
    logic ext_input;
    logic doorbell;
  } Except_base;

endpackage

// File: rtl/pu_int_ctrl_pin_filter.sv
// One gin pin: multi-flop synchronizer followed by a stability filter that only
// accepts a new value after it has been seen for FILTER_LEN consecutive cycles.
module pu_int_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    cnt_d  = '0;
    filt_d = filt_q;
    if (s != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/pu_int_ctrl.sv
// External interrupt controller: conditions the gin pins and doorbell events into
// pending bits and raises the ext_input / doorbell exception requests.
module pu_int_ctrl
  import Pu_interrupt::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          ctrl,
  input  logic [GIN_WIDTH-1:0] gin,
  input  logic                 doorbell_msg,
  input  logic                 doorbell_clr,
  input  logic [GIN_WIDTH-1:0] pend_clr,
  output logic                 ext_input,
  output logic                 doorbell,
  output logic [GIN_WIDTH-1:0] status
);

  Int_ctrl_reg          ctrl_s;
  Except_base           req;
  logic [GIN_WIDTH-1:0] filt;
  logic [GIN_WIDTH-1:0] filt_q, filt_d;
  logic [GIN_WIDTH-1:0] pend_q, pend_d;
  logic                 db_pend_q, db_pend_d;
  logic [GIN_WIDTH-1:0] act_now, act_prev, edge_det;
  logic                 unused_rsvd;

  assign ctrl_s      = ctrl;
  assign unused_rsvd = ^ctrl_s.rsvd;

  for (genvar i = 0; i < GIN_WIDTH; i++) begin : g_pin
    pu_int_pin_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_filter (
      .clk  (clk),
      .reset(reset),
      .pin  (gin[i]),
      .filt (filt[i])
    );
  end

  // Both samples use the current trigger, so a trigger change alone never looks like an edge.
  always_comb begin
    act_now   = filt ^ ctrl_s.gin_trigger;
    act_prev  = filt_q ^ ctrl_s.gin_trigger;
    edge_det  = act_now & ~act_prev;
    filt_d    = filt;
    pend_d    = (ctrl_s.gin_sense_level & act_now)
              | (~ctrl_s.gin_sense_level & (edge_det | (pend_q & ~pend_clr)));
    db_pend_d = doorbell_msg | (db_pend_q & ~doorbell_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q    <= '0;
      pend_q    <= '0;
      db_pend_q <= 1'b0;
    end else begin
      filt_q    <= filt_d;
      pend_q    <= pend_d;
      db_pend_q <= db_pend_d;
    end
  end

  always_comb begin
    req.ext_input = |(pend_q & ctrl_s.gin_mask);
    req.doorbell  = db_pend_q & ctrl_s.doorbell_en;
  end

  assign ext_input = req.ext_input;
  assign doorbell  = req.doorbell;
  assign status    = pend_q;

endmodule

// File: tb/tb_pu_int_ctrl.sv
// Self-checking bench for pu_int_ctrl: a table of per-cycle vectors whose expected
// outputs go through a scoreboard queue, plus combinational ctrl probes.
module tb_pu_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ctrl;
  logic [3:0]  gin;
  logic        doorbell_msg;
  logic        doorbell_clr;
  logic [3:0]  pend_clr;
  logic        ext_input;
  logic        doorbell;
  logic [3:0]  status;

  pu_int_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl        (ctrl),
    .gin         (gin),
    .doorbell_msg(doorbell_msg),
    .doorbell_clr(doorbell_clr),
    .pend_clr    (pend_clr),
    .ext_input   (ext_input),
    .doorbell    (doorbell),
    .status      (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        comb;
    logic        rst;
    logic [31:0] ctrl;
    logic [3:0]  gin;
    logic        msg;
    logic        clr;
    logic [3:0]  pclr;
    logic        exp_ext;
    logic        exp_db;
    logic [3:0]  exp_st;
  } vec_t;

  typedef struct {
    string      name;
    logic       ext;
    logic       db;
    logic [3:0] st;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reserved bits are set to a non-zero pattern so they are exercised as don't-cares.
  function automatic logic [31:0] mk_ctrl(input logic [3:0] mask, input logic [3:0] trig,
                                          input logic [3:0] lvl, input logic en);
    mk_ctrl = {19'h2A5A5, en, lvl, trig, mask};
  endfunction

  task automatic add(input string name, input int n, input logic comb, input logic rst,
                     input logic [31:0] c, input logic [3:0] g, input logic m, input logic cl,
                     input logic [3:0] pc, input logic e_ext, input logic e_db,
                     input logic [3:0] e_st);
    vec_t v;
    v.name = name; v.comb = comb; v.rst = rst; v.ctrl = c; v.gin = g; v.msg = m;
    v.clr = cl; v.pclr = pc; v.exp_ext = e_ext; v.exp_db = e_db; v.exp_st = e_st;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic compare_one();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".ext_input"}, 32'(ext_input), 32'(e.ext));
      check({e.name, ".doorbell"}, 32'(doorbell), 32'(e.db));
      check({e.name, ".status"}, 32'(status), 32'(e.st));
    end
  endtask

  initial begin
    logic [31:0] c_l0, c_g, c_e2, c_m0, c_m1, c_d0, c_d1, c_r0, c_r1;
    exp_t e;
    c_l0 = mk_ctrl(4'b0001, 4'b0000, 4'b1111, 1'b0);
    c_g  = mk_ctrl(4'b0010, 4'b0000, 4'b1111, 1'b0);
    c_e2 = mk_ctrl(4'b0100, 4'b0100, 4'b0000, 1'b0);
    c_m0 = mk_ctrl(4'b0000, 4'b0000, 4'b0000, 1'b0);
    c_m1 = mk_ctrl(4'b1000, 4'b0000, 4'b0000, 1'b0);
    c_d0 = mk_ctrl(4'b0000, 4'b0000, 4'b0000, 1'b0);
    c_d1 = mk_ctrl(4'b0000, 4'b0000, 4'b0000, 1'b1);
    c_r0 = mk_ctrl(4'b0101, 4'b0000, 4'b0000, 1'b1);
    c_r1 = mk_ctrl(4'b1111, 4'b1111, 4'b0000, 1'b1);

    //   name                  n  comb rst ctrl  gin      msg  clr  pclr     ext  db   status
    add("reset",               2, 0, 1, c_d0, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    // Level mode: pend follows the pin 4 cycles after the sampling edge.
    add("lvl_idle",            2, 0, 0, c_l0, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("lvl_rise_wait",       4, 0, 0, c_l0, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("lvl_rise",            1, 0, 0, c_l0, 4'b0001, 0, 0, 4'b0000, 1, 0, 4'b0001);
    add("lvl_clr_ignored",     2, 0, 0, c_l0, 4'b0001, 0, 0, 4'b0001, 1, 0, 4'b0001);
    add("lvl_fall_wait",       4, 0, 0, c_l0, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0001);
    add("lvl_fall",            1, 0, 0, c_l0, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    // A one-cycle pulse never survives the filter.
    add("glitch_pulse",        1, 0, 0, c_g,  4'b0010, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("glitch_quiet",        7, 0, 0, c_g,  4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    // Falling-edge mode on pin 2.
    add("e2_high",             7, 0, 0, c_e2, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("e2_fall_wait",        4, 0, 0, c_e2, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("e2_fall",             1, 0, 0, c_e2, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0100);
    add("e2_pin_high",         7, 0, 0, c_e2, 4'b0100, 0, 0, 4'b0000, 1, 0, 4'b0100);
    add("e2_clr",              1, 0, 0, c_e2, 4'b0100, 0, 0, 4'b0100, 0, 0, 4'b0000);
    add("e2_after_clr",        1, 0, 0, c_e2, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("e2_fall2_wait",       4, 0, 0, c_e2, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("e2_set_wins",         1, 0, 0, c_e2, 4'b0000, 0, 0, 4'b0100, 1, 0, 4'b0100);
    add("e2_set_hold",         1, 0, 0, c_e2, 4'b0000, 0, 0, 4'b0000, 1, 0, 4'b0100);
    add("e2_clr2",             1, 0, 0, c_e2, 4'b0000, 0, 0, 4'b0100, 0, 0, 4'b0000);
    // Masked rising edge on pin 3; trigger flip on pin 2 must not create an edge.
    add("m3_rise_wait",        4, 0, 0, c_m0, 4'b1000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("m3_masked",           1, 0, 0, c_m0, 4'b1000, 0, 0, 4'b0000, 0, 0, 4'b1000);
    add("m3_unmask_comb",      1, 1, 0, c_m1, 4'b1000, 0, 0, 4'b0000, 1, 0, 4'b1000);
    add("m3_unmasked",         1, 0, 0, c_m1, 4'b1000, 0, 0, 4'b0000, 1, 0, 4'b1000);
    add("m3_clr",              1, 0, 0, c_m1, 4'b1000, 0, 0, 4'b1000, 0, 0, 4'b0000);
    // Doorbell.
    add("db_msg_dis",          1, 0, 0, c_d0, 4'b1000, 1, 0, 4'b0000, 0, 0, 4'b0000);
    add("db_en_comb",          1, 1, 0, c_d1, 4'b1000, 0, 0, 4'b0000, 0, 1, 4'b0000);
    add("db_en",               1, 0, 0, c_d1, 4'b1000, 0, 0, 4'b0000, 0, 1, 4'b0000);
    add("db_msg_clr",          1, 0, 0, c_d1, 4'b1000, 1, 1, 4'b0000, 0, 1, 4'b0000);
    add("db_clr",              1, 0, 0, c_d1, 4'b1000, 0, 1, 4'b0000, 0, 0, 4'b0000);
    add("db_idle",             1, 0, 0, c_d1, 4'b1000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    // Reset in the middle of activity, then idle-low pins with falling trigger.
    add("pre_rst_wait",        4, 0, 0, c_r0, 4'b1101, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("pre_rst_pend",        1, 0, 0, c_r0, 4'b1101, 0, 0, 4'b0000, 1, 0, 4'b0101);
    add("pre_rst_db",          1, 0, 0, c_r0, 4'b1101, 1, 0, 4'b0000, 1, 1, 4'b0101);
    add("mid_rst",             1, 0, 1, c_r1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    add("post_rst_idle",      20, 0, 0, c_r1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      reset        = vecs[i].rst;
      ctrl         = vecs[i].ctrl;
      gin          = vecs[i].gin;
      doorbell_msg = vecs[i].msg;
      doorbell_clr = vecs[i].clr;
      pend_clr     = vecs[i].pclr;
      e.name = vecs[i].name;
      e.ext  = vecs[i].exp_ext;
      e.db   = vecs[i].exp_db;
      e.st   = vecs[i].exp_st;
      exp_q.push_back(e);
      if (!vecs[i].comb) @(posedge clk);
      #1;
      compare_one();
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
